arb8_rr: RTL and testbench



---
 rtl/arb8_rr_pkg.sv | 23 ++
 rtl/arb8_rr_pick8.sv | 25 ++
 rtl/arb8_rr.sv | 134 +++++++++++++
 tb/tb_arb8_rr.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/arb8_rr_pkg.sv
// Shared definitions for the eight-way round-robin arbiter: state encoding,
// requester geometry and a one-hot to binary index helper.
package arb8_rr_pkg;

  localparam int NREQ = 8;
  localparam int IDXW = 3;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // OR-accumulate positions; valid because the input is one-hot or zero.
  function automatic logic [IDXW-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
    logic [IDXW-1:0] idx;
    idx = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      idx = idx | (oh[i] ? IDXW'(i) : 3'd0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb8_rr_pick8.sv
// rr_pick8: combinational round-robin picker. Returns the first set mask bit
// at or after `start`, wrapping modulo 8, as a one-hot vector.
module rr_pick8
  import arb8_rr_pkg::*;
(
  input  logic [NREQ-1:0] mask,
  input  logic [IDXW-1:0] start,
  output logic [NREQ-1:0] winner,
  output logic            valid
);

  logic [2*NREQ-1:0] dbl_s;
  logic [NREQ-1:0]   rot_s;
  logic [NREQ-1:0]   rot_pick_s;
  logic [2*NREQ-1:0] back_s;

  // Rotate so `start` sits at bit 0, isolate the lowest set bit, rotate back.
  assign dbl_s      = {mask, mask} >> start;
  assign rot_s      = dbl_s[NREQ-1:0];
  assign rot_pick_s = rot_s & (~rot_s + 8'd1);
  assign back_s     = {rot_pick_s, rot_pick_s} << start;
  assign winner     = back_s[2*NREQ-1:NREQ];
  assign valid      = |mask;

endmodule

// File: rtl/arb8_rr.sv
// arb8_rr: eight-way round-robin arbiter with registered one-hot grant.
// Optional forced rotation after MAX_HOLD cycles: define ARB8_HOLD_TIMEOUT_EN.
module arb8_rr
  import arb8_rr_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            busy,
  output logic            any_req
);

  arb_state_t      state_r, state_s;
  logic [IDXW-1:0] last_r, last_s;
  logic [NREQ-1:0] gnt_r, gnt_s;
  logic [IDXW-1:0] gnt_idx_r, gnt_idx_s;
  logic            busy_r, busy_s;
  logic            new_grant_s;
  logic            holder_req_s;
  logic            timeout_s;
  logic [NREQ-1:0] pick_mask_s, pick_win_s;
  logic            pick_valid_s;

  assign any_req      = |req;
  assign holder_req_s = |(req & gnt_r);
  // The holder is masked out so a release or timeout hands off to someone else.
  assign pick_mask_s  = (state_r == ARB_GRANT) ? (req & ~gnt_r) : req;

  rr_pick8 u_pick (
    .mask   (pick_mask_s),
    .start  (last_r + 3'd1),
    .winner (pick_win_s),
    .valid  (pick_valid_s)
  );

`ifdef ARB8_HOLD_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt_r;

  assign timeout_s = (state_r == ARB_GRANT) && (hold_cnt_r == HOLD_LAST) && pick_valid_s;

  // Hold counter: restarts per grant, saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_r <= 8'd0;
    end else if (new_grant_s || (state_s == ARB_IDLE)) begin
      hold_cnt_r <= 8'd0;
    end else if (hold_cnt_r != HOLD_LAST) begin
      hold_cnt_r <= hold_cnt_r + 8'd1;
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and next-grant selection.
  always_comb begin
    state_s     = state_r;
    last_s      = last_r;
    gnt_s       = gnt_r;
    gnt_idx_s   = gnt_idx_r;
    busy_s      = busy_r;
    new_grant_s = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (pick_valid_s) begin
          state_s     = ARB_GRANT;
          gnt_s       = pick_win_s;
          gnt_idx_s   = onehot_to_idx(pick_win_s);
          last_s      = onehot_to_idx(pick_win_s);
          busy_s      = 1'b1;
          new_grant_s = 1'b1;
        end else begin
          state_s   = ARB_IDLE;
          gnt_s     = 8'd0;
          gnt_idx_s = 3'd0;
          busy_s    = 1'b0;
        end
      end
      ARB_GRANT: begin
        if (holder_req_s && !timeout_s) begin
          state_s = ARB_GRANT;
        end else if (pick_valid_s) begin
          gnt_s       = pick_win_s;
          gnt_idx_s   = onehot_to_idx(pick_win_s);
          last_s      = onehot_to_idx(pick_win_s);
          busy_s      = 1'b1;
          new_grant_s = 1'b1;
        end else if (!holder_req_s) begin
          state_s   = ARB_IDLE;
          gnt_s     = 8'd0;
          gnt_idx_s = 3'd0;
          busy_s    = 1'b0;
        end else begin
          state_s = ARB_GRANT;
        end
      end
      default: begin
        state_s   = ARB_IDLE;
        gnt_s     = 8'd0;
        gnt_idx_s = 3'd0;
        busy_s    = 1'b0;
      end
    endcase
  end

  // State, pointer and grant registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ARB_IDLE;
      last_r    <= 3'd7;
      gnt_r     <= 8'd0;
      gnt_idx_r <= 3'd0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      last_r    <= last_s;
      gnt_r     <= gnt_s;
      gnt_idx_r <= gnt_idx_s;
      busy_r    <= busy_s;
    end
  end

  assign gnt     = gnt_r;
  assign gnt_idx = gnt_idx_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_arb8_rr.sv
// Self-checking bench for arb8_rr; expected outputs are queued when stimulus is
// driven and compared after the clock edge that should produce them.
module tb_arb8_rr;

`ifdef ARB8_HOLD_TIMEOUT_EN
  localparam int HOLD = 4;
`else
  localparam int HOLD = 16;
`endif

  typedef struct packed {
    logic [7:0] r;
    logic       rs;
    logic [7:0] g;
    logic [2:0] i;
  } step_t;

  typedef struct {
    logic [7:0] g;
    logic [2:0] i;
    logic       b;
    logic       a;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = 8'd0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       busy;
  logic       any_req;

  exp_t sbq[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  arb8_rr #(.MAX_HOLD(HOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .any_req (any_req)
  );

  always #5 clk = ~clk;

  task automatic drive(input step_t s);
    @(negedge clk);
    req   = s.r;
    reset = s.rs;
    sbq.push_back('{g: s.g, i: s.i, b: (s.g != 8'd0), a: (s.r != 8'd0)});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t s[7];
    s = '{'{8'h00, 1'b1, 8'h00, 3'd0}, '{8'h00, 1'b1, 8'h00, 3'd0},
          '{8'h00, 1'b0, 8'h00, 3'd0}, '{8'h00, 1'b0, 8'h00, 3'd0},
          '{8'h00, 1'b0, 8'h00, 3'd0}, '{8'h00, 1'b0, 8'h00, 3'd0},
          '{8'h00, 1'b0, 8'h00, 3'd0}};
    for (int k = 0; k < 7; k++) begin
      drive(s[k]);
      e = sbq.pop_front();
      n_cmp++;
      if (gnt !== e.g || gnt_idx !== e.i || busy !== e.b || any_req !== e.a) begin
        n_bad++;
        $display("FAIL reset[%0d]: got gnt=%b idx=%0d busy=%b any=%b, want gnt=%b idx=%0d busy=%b any=%b",
                 k, gnt, gnt_idx, busy, any_req, e.g, e.i, e.b, e.a);
      end
    end
  endtask

  task automatic test_handoff();
    step_t s[4];
    s = '{'{8'h00, 1'b1, 8'h00, 3'd0}, '{8'h24, 1'b0, 8'h04, 3'd2},
          '{8'h20, 1'b0, 8'h20, 3'd5}, '{8'h00, 1'b0, 8'h00, 3'd0}};
    for (int k = 0; k < 4; k++) begin
      drive(s[k]);
      e = sbq.pop_front();
      n_cmp++;
      if (gnt !== e.g || gnt_idx !== e.i || busy !== e.b || any_req !== e.a) begin
        n_bad++;
        $display("FAIL handoff[%0d]: got gnt=%b idx=%0d busy=%b any=%b, want gnt=%b idx=%0d busy=%b any=%b",
                 k, gnt, gnt_idx, busy, any_req, e.g, e.i, e.b, e.a);
      end
    end
  endtask

  task automatic test_rotation();
    step_t s;
    logic [7:0] one;
    one = 8'd1;
    drive('{8'h00, 1'b1, 8'h00, 3'd0});
    e = sbq.pop_front();
    drive('{8'hFF, 1'b0, 8'h01, 3'd0});
    e = sbq.pop_front();
    n_cmp++;
    if (gnt !== e.g || gnt_idx !== e.i || busy !== e.b) begin
      n_bad++;
      $display("FAIL rotation_first: got gnt=%b idx=%0d busy=%b, want gnt=%b idx=%0d busy=%b",
               gnt, gnt_idx, busy, e.g, e.i, e.b);
    end
    // Holder k drops for one cycle, everybody else keeps requesting.
    for (int k = 0; k < 9; k++) begin
      s.r  = ~(one << (k % 8));
      s.rs = 1'b0;
      s.g  = one << ((k + 1) % 8);
      s.i  = 3'((k + 1) % 8);
      drive(s);
      e = sbq.pop_front();
      n_cmp++;
      if (gnt !== e.g || gnt_idx !== e.i || busy !== e.b) begin
        n_bad++;
        $display("FAIL rotation[%0d]: got gnt=%b idx=%0d busy=%b, want gnt=%b idx=%0d busy=%b",
                 k, gnt, gnt_idx, busy, e.g, e.i, e.b);
      end
    end
  endtask

  task automatic test_release_idle();
    step_t s[5];
    s = '{'{8'h00, 1'b1, 8'h00, 3'd0}, '{8'h08, 1'b0, 8'h08, 3'd3},
          '{8'h00, 1'b0, 8'h00, 3'd0}, '{8'h00, 1'b0, 8'h00, 3'd0},
          '{8'h01, 1'b0, 8'h01, 3'd0}};
    for (int k = 0; k < 5; k++) begin
      drive(s[k]);
      e = sbq.pop_front();
      n_cmp++;
      if (gnt !== e.g || gnt_idx !== e.i || busy !== e.b || any_req !== e.a) begin
        n_bad++;
        $display("FAIL release_idle[%0d]: got gnt=%b idx=%0d busy=%b any=%b, want gnt=%b idx=%0d busy=%b any=%b",
                 k, gnt, gnt_idx, busy, any_req, e.g, e.i, e.b, e.a);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    step_t s[5];
    s = '{'{8'h00, 1'b1, 8'h00, 3'd0}, '{8'h80, 1'b0, 8'h80, 3'd7},
          '{8'h80, 1'b1, 8'h00, 3'd0}, '{8'h81, 1'b0, 8'h01, 3'd0},
          '{8'h81, 1'b0, 8'h01, 3'd0}};
    for (int k = 0; k < 5; k++) begin
      drive(s[k]);
      e = sbq.pop_front();
      n_cmp++;
      if (gnt !== e.g || gnt_idx !== e.i || busy !== e.b) begin
        n_bad++;
        $display("FAIL reset_mid[%0d]: got gnt=%b idx=%0d busy=%b, want gnt=%b idx=%0d busy=%b",
                 k, gnt, gnt_idx, busy, e.g, e.i, e.b);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t s[8];
    s = '{'{8'h00, 1'b1, 8'h00, 3'd0}, '{8'h01, 1'b0, 8'h01, 3'd0},
          '{8'h04, 1'b0, 8'h04, 3'd2}, '{8'h06, 1'b0, 8'h04, 3'd2},
          '{8'h02, 1'b0, 8'h02, 3'd1}, '{8'h06, 1'b0, 8'h02, 3'd1},
          '{8'h04, 1'b0, 8'h04, 3'd2}, '{8'h00, 1'b0, 8'h00, 3'd0}};
    for (int k = 0; k < 8; k++) begin
      drive(s[k]);
      e = sbq.pop_front();
      n_cmp++;
      if (gnt !== e.g || gnt_idx !== e.i || busy !== e.b) begin
        n_bad++;
        $display("FAIL back_to_back[%0d]: got gnt=%b idx=%0d busy=%b, want gnt=%b idx=%0d busy=%b",
                 k, gnt, gnt_idx, busy, e.g, e.i, e.b);
      end
    end
  endtask

  task automatic test_hold();
    step_t s;
    drive('{8'h00, 1'b1, 8'h00, 3'd0});
    e = sbq.pop_front();
    for (int k = 0; k < 20; k++) begin
      s.r  = 8'h03;
      s.rs = 1'b0;
`ifdef ARB8_HOLD_TIMEOUT_EN
      s.g = (((k / 4) % 2) == 1) ? 8'h02 : 8'h01;
      s.i = (((k / 4) % 2) == 1) ? 3'd1 : 3'd0;
`else
      s.g = 8'h01;
      s.i = 3'd0;
`endif
      drive(s);
      e = sbq.pop_front();
      n_cmp++;
      if (gnt !== e.g || gnt_idx !== e.i || busy !== e.b) begin
        n_bad++;
        $display("FAIL hold[%0d]: got gnt=%b idx=%0d busy=%b, want gnt=%b idx=%0d busy=%b",
                 k, gnt, gnt_idx, busy, e.g, e.i, e.b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_handoff();
    test_rotation();
    test_release_idle();
    test_reset_mid_grant();
    test_back_to_back();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
